// File: rtl/signed_seg7_scan.sv
// signed_seg7_scan: converts a signed two's-complement value to BCD with a
// sequential double-dabble and drives a multiplexed seven-segment display
// (active-low segments and digit enables, sign lamp, overflow dashes).
module signed_seg7_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              ready,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              neg_n,
  output logic              ovf
);

  localparam int NB = (WIDTH + 2) / 3;
  localparam int BW = 4 * NB;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic             sign_q;
  logic [BW-1:0]    disp_bcd;
  logic             ovf_new;
  logic [PW-1:0]    presc;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_next;
  logic             presc_wrap;
  logic [BW-1:0]    src_bcd;
  logic             src_ovf;
  logic [3:0]       cur_dig;
  logic             upper_zero;
  logic [6:0]       seg_next;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign ready = (state == S_IDLE);

  // Double-dabble correction: add 3 to every BCD digit of 5 or more.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < NB; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Overflow: any converted digit beyond the physical digit count is nonzero.
  always_comb begin
    ovf_new = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((i >= DIGITS) && (bcd[4*i +: 4] != 4'd0)) ovf_new = 1'b1;
    end
  end

  // Conversion FSM: capture magnitude, WIDTH shift steps, then commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mag      <= '0;
      bcd      <= '0;
      sign_q   <= 1'b0;
      disp_bcd <= '0;
      neg_n    <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            sign_q <= value[WIDTH-1];
            mag    <= value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
            bcd    <= '0;
            cnt    <= '0;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          bcd <= {bcd_adj[BW-2:0], mag[WIDTH-1]};
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          disp_bcd <= bcd;
          neg_n    <= ~sign_q;
          ovf      <= ovf_new;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign presc_wrap = (presc == PW'(SCAN_DIV - 1));

  // Next digit index; advances only when the prescaler wraps.
  always_comb begin
    idx_next = idx;
    if (presc_wrap) idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // Segment source bypasses the display registers during COMMIT so the
  // registered seg output shows the new result on the same edge it commits.
  always_comb begin
    src_bcd    = (state == S_COMMIT) ? bcd : disp_bcd;
    src_ovf    = (state == S_COMMIT) ? ovf_new : ovf;
    cur_dig    = 4'd0;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i == 32'(idx_next)) cur_dig = src_bcd[4*i +: 4];
      if ((i >= 32'(idx_next)) && (src_bcd[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    if (src_ovf) seg_next = SEG_DASH;
    else if ((idx_next != '0) && upper_zero) seg_next = SEG_BLANK;
    else seg_next = glyph(cur_dig);
  end

  // Free-running scan: prescaler, digit index and registered an/seg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      an    <= ~DIGITS'(1);
      seg   <= 7'b1000000;
    end else begin
      presc <= presc_wrap ? '0 : presc + PW'(1);
      idx   <= idx_next;
      an    <= ~(DIGITS'(1) << idx_next);
      seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_signed_seg7_scan.sv
// tb_signed_seg7_scan: table-driven check of two instances (3 and 2 digits,
// fast scan) plus hand sequences for scan order, ignored load and reset abort.
module tb_signed_seg7_scan;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G5 = 7'b0010010, G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111, DS = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value_a = '0, value_b = '0;
  logic       load_a = 1'b0, load_b = 1'b0;
  logic       ready_a, ready_b, neg_n_a, neg_n_b, ovf_a, ovf_b;
  logic [6:0] seg_a, seg_b;
  logic [2:0] an_a;
  logic [1:0] an_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  signed_seg7_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .value(value_a), .load(load_a), .ready(ready_a),
    .seg(seg_a), .an(an_a), .neg_n(neg_n_a), .ovf(ovf_a));

  signed_seg7_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .value(value_b), .load(load_b), .ready(ready_b),
    .seg(seg_b), .an(an_b), .neg_n(neg_n_b), .ovf(ovf_b));

  typedef struct {
    int         sel;
    logic [7:0] val;
    logic [6:0] s0, s1, s2;
    logic       neg;
    logic       ov;
  } vec_t;

  vec_t tbl[13];
  logic [6:0] pa[3];
  logic [6:0] pb[3];

  function automatic logic [2:0] an_of(input int s);
    return (s == 0) ? an_a : {1'b1, an_b};
  endfunction
  function automatic logic [6:0] seg_of(input int s);
    return (s == 0) ? seg_a : seg_b;
  endfunction
  function automatic logic rdy_of(input int s);
    return (s == 0) ? ready_a : ready_b;
  endfunction
  function automatic int dec_an(input logic [2:0] a);
    case (a)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [7:0] v, input logic l);
    if (sel == 0) begin value_a = v; load_a = l; end
    else begin value_b = v; load_b = l; end
  endtask

  // Issue one load and count busy cycles; seg must keep showing prev meanwhile.
  task automatic run_vec(input int sel, input logic [7:0] v, input bit mid_pulse,
                         input logic [6:0] p0, p1, p2, output int busy, output int held);
    int n;
    int k;
    logic [6:0] pr[3];
    pr[0] = p0; pr[1] = p1; pr[2] = p2;
    n = 0;
    while (!rdy_of(sel) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_bad++;
      $display("FAIL wait_ready: got timeout expected ready");
    end
    @(negedge clk);
    drive(sel, v, 1'b1);
    @(posedge clk); #1;
    drive(sel, v, 1'b0);
    busy = 0;
    held = 1;
    while (busy < 50) begin
      @(negedge clk);
      if (rdy_of(sel)) break;
      busy++;
      k = dec_an(an_of(sel));
      if (k < 0 || seg_of(sel) !== pr[k]) held = 0;
      if (mid_pulse && busy == 3) drive(sel, ~v, 1'b1);
      if (mid_pulse && busy == 4) drive(sel, v, 1'b0);
    end
  endtask

  task automatic capture(input int sel, output logic [6:0] d0, d1, d2,
                         output int seen, output int bad_an);
    int k;
    d0 = '0; d1 = '0; d2 = '0; seen = 0; bad_an = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      k = dec_an(an_of(sel));
      case (k)
        0: begin d0 = seg_of(sel); seen |= 1; end
        1: begin d1 = seg_of(sel); seen |= 2; end
        2: begin d2 = seg_of(sel); seen |= 4; end
        default: bad_an++;
      endcase
    end
  endtask

  task automatic check_display(input int sel, input logic [6:0] e0, e1, e2,
                               input logic en, input logic eo);
    logic [6:0] d0, d1, d2;
    int seen, bad_an;
    capture(sel, d0, d1, d2, seen, bad_an);
    check("an_onehot", 32'(bad_an), 0);
    check("digits_seen", 32'(seen), (sel == 0) ? 7 : 3);
    check("digit0", 32'(d0), 32'(e0));
    check("digit1", 32'(d1), 32'(e1));
    if (sel == 0) check("digit2", 32'(d2), 32'(e2));
    check("neg_n", 32'((sel == 0) ? neg_n_a : neg_n_b), 32'(en));
    check("ovf", 32'((sel == 0) ? ovf_a : ovf_b), 32'(eo));
  endtask

  initial begin
    int busy, held, n;
    logic [2:0] exp_an_a[3];
    logic [1:0] exp_an_b[2];
    exp_an_a[0] = 3'b110; exp_an_a[1] = 3'b101; exp_an_a[2] = 3'b011;
    exp_an_b[0] = 2'b10;  exp_an_b[1] = 2'b01;

    tbl[0]  = '{0, 8'd123, G3, G2, G1, 1'b1, 1'b0};
    tbl[1]  = '{0, 8'h80,  G8, G2, G1, 1'b0, 1'b0};
    tbl[2]  = '{0, 8'hFB,  G5, BL, BL, 1'b0, 1'b0};
    tbl[3]  = '{0, 8'd0,   G0, BL, BL, 1'b1, 1'b0};
    tbl[4]  = '{0, 8'd10,  G0, G1, BL, 1'b1, 1'b0};
    tbl[5]  = '{0, 8'd100, G0, G0, G1, 1'b1, 1'b0};
    tbl[6]  = '{0, 8'd127, G7, G2, G1, 1'b1, 1'b0};
    tbl[7]  = '{0, 8'hFF,  G1, BL, BL, 1'b0, 1'b0};
    tbl[8]  = '{1, 8'd100, DS, DS, BL, 1'b1, 1'b1};
    tbl[9]  = '{1, 8'd99,  G9, G9, BL, 1'b1, 1'b0};
    tbl[10] = '{1, 8'h80,  DS, DS, BL, 1'b0, 1'b1};
    tbl[11] = '{1, 8'h9D,  G9, G9, BL, 1'b0, 1'b0};
    tbl[12] = '{1, 8'd10,  G0, G1, BL, 1'b1, 1'b0};
    pa[0] = G0; pa[1] = BL; pa[2] = BL;
    pb[0] = G0; pb[1] = BL; pb[2] = BL;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an_a), 32'(3'b110));
    check("rst_seg", 32'(seg_a), 32'(G0));
    check("rst_neg_n", 32'(neg_n_a), 1);
    check("rst_ovf", 32'(ovf_a), 0);
    check("rst_ready", 32'(ready_a), 1);
    check("rst_an_b", 32'(an_b), 32'(2'b10));

    // Scan order after reset release
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("scan_an_a", 32'(an_a), 32'(exp_an_a[(k / 4) % 3]));
      check("scan_an_b", 32'(an_b), 32'(exp_an_b[(k / 4) % 2]));
    end

    // Table of conversions
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].sel == 0) run_vec(0, tbl[i].val, 1'b0, pa[0], pa[1], pa[2], busy, held);
      else run_vec(1, tbl[i].val, 1'b0, pb[0], pb[1], pb[2], busy, held);
      check("busy_cycles", 32'(busy), 9);
      check("held_during_conv", 32'(held), 1);
      check_display(tbl[i].sel, tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].neg, tbl[i].ov);
      if (tbl[i].sel == 0) begin pa[0] = tbl[i].s0; pa[1] = tbl[i].s1; pa[2] = tbl[i].s2; end
      else begin pb[0] = tbl[i].s0; pb[1] = tbl[i].s1; end
    end

    // load pulsed mid-conversion is ignored and not queued
    run_vec(0, 8'd123, 1'b1, pa[0], pa[1], pa[2], busy, held);
    check("midload_busy", 32'(busy), 9);
    check("midload_held", 32'(held), 1);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!ready_a) n++;
    end
    check("midload_not_queued", 32'(n), 0);
    check_display(0, G3, G2, G1, 1'b1, 1'b0);

    // Reset during conversion aborts it
    @(negedge clk);
    value_a = 8'h9D; load_a = 1'b1;
    @(posedge clk); #1;
    load_a = 1'b0;
    repeat (4) @(negedge clk);
    check("conv_busy_before_rst", 32'(ready_a), 0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready_a), 1);
    check("abort_an", 32'(an_a), 32'(3'b110));
    check("abort_seg", 32'(seg_a), 32'(G0));
    check("abort_neg_n", 32'(neg_n_a), 1);
    check("abort_ovf", 32'(ovf_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ready_a) n++;
    end
    check("abort_stays_idle", 32'(n), 0);
    check_display(0, G0, BL, BL, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
